mips_mem_loader: RTL and testbench

//   Boot loader that writes the MIPS instruction and data memories from a byte stream.
//   It is the writer counterpart to the end-of-run register/memory dump.
//   It sits beside the single-cycle core, drives the memory write ports, and holds
//   the core via cpu_hold until a frame with a good checksum has been loaded.

---
 rtl/mips_mem_loader.sv | 139 +++++++++++++
 tb/tb_mips_mem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_loader.sv
// Boot loader: parses SYNC/TARGET/ADDR/COUNT/DATA/CHK frames from a byte stream,
// writes big-endian words into imem or dmem, and holds the core until a frame verifies.
module mips_mem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_TARGET, S_ADDR, S_COUNT, S_DATA, S_CHECK
   } state_t;

   state_t            r_state, w_next;
   logic              r_in_ready;
   logic              r_target;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_count;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_shift;
   logic [7:0]        r_chk;
   logic              r_imem_we, r_dmem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_done, r_err;
   logic              w_accept;
   logic              w_word_end;

   assign w_accept   = in_valid && r_in_ready;
   assign w_word_end = (r_byte_cnt == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: w_next gets its default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      if (w_accept) begin
         case (r_state)
            S_IDLE:   if (in_data == SYNC) w_next = S_TARGET;
            S_TARGET: w_next = (in_data[7:1] == 7'd0) ? S_ADDR : S_IDLE;
            S_ADDR:   w_next = S_COUNT;
            S_COUNT:  w_next = (in_data == 8'd0) ? S_CHECK : S_DATA;
            S_DATA:   if (w_word_end && r_count == 8'd1) w_next = S_CHECK;
            S_CHECK:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready  <= 1'b0;
         r_target    <= 1'b0;
         r_addr      <= '0;
         r_count     <= 8'd0;
         r_byte_cnt  <= 2'd0;
         r_shift     <= 24'd0;
         r_chk       <= 8'd0;
         r_imem_we   <= 1'b0;
         r_dmem_we   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready <= 1'b1;
         r_imem_we  <= 1'b0;
         r_dmem_we  <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_IDLE: if (in_data == SYNC) begin
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  r_chk  <= 8'd0;
               end
               S_TARGET: begin
                  r_target <= in_data[0];
                  r_chk    <= r_chk ^ in_data;
                  if (in_data[7:1] != 7'd0) r_err <= 1'b1;
               end
               S_ADDR: begin
                  r_addr <= in_data[ADDR_W-1:0];
                  r_chk  <= r_chk ^ in_data;
               end
               S_COUNT: begin
                  r_count    <= in_data;
                  r_byte_cnt <= 2'd0;
                  r_chk      <= r_chk ^ in_data;
               end
               S_DATA: begin
                  r_shift    <= {r_shift[15:0], in_data};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_chk      <= r_chk ^ in_data;
                  if (w_word_end) begin
                     // Completed word: strobe next cycle, then advance with wrap-around.
                     r_imem_we   <= ~r_target;
                     r_dmem_we   <= r_target;
                     r_mem_addr  <= r_addr;
                     r_mem_wdata <= {r_shift, in_data};
                     r_addr      <= r_addr + 1'b1;
                     r_count     <= r_count - 8'd1;
                  end
               end
               S_CHECK: begin
                  if (in_data == r_chk) r_done <= 1'b1;
                  else                  r_err  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign imem_we   = r_imem_we;
   assign dmem_we   = r_dmem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign done      = r_done;
   assign cpu_hold  = ~r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_mips_mem_loader.sv
// Self-checking bench for mips_mem_loader: table of frames plus hand-written
// junk, reset-mid-frame and back-to-back sequences; strobes checked via a scoreboard.
module tb_mips_mem_loader;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              imem_we, dmem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold, done, err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [7:0]       target;
      logic [7:0]       addr;
      logic [7:0]       count;
      logic [1:0][31:0] words;
      logic             bad_chk;
      logic [7:0]       chk_val;
      logic             exp_done;
      logic             exp_err;
   } frame_t;

   typedef struct packed {
      logic              dmem;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t    exp_q[$];
   frame_t tbl[6];

   mips_mem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && (imem_we || dmem_we)) begin
         wr_t e;
         check("we_exclusive", {31'd0, imem_we & dmem_we}, 32'd0);
         check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("strobe_target", {31'd0, dmem_we}, {31'd0, e.dmem});
            check("strobe_addr", {26'd0, mem_addr}, {26'd0, e.addr});
            check("strobe_data", mem_wdata, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      check("in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
      check("rst_addr", {26'd0, mem_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_err", {31'd0, err}, 32'd0);
   endtask

   task automatic send_frame(input frame_t f);
      logic [7:0]        chk;
      logic [7:0]        b;
      logic [ADDR_W-1:0] a;
      wr_t               e;
      send_byte(8'hA5);
      check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
      check("done_after_sync", {31'd0, done}, 32'd0);
      send_byte(f.target);
      if (f.target > 8'd1) begin
         check("badtgt_err", {31'd0, err}, 32'd1);
         check("badtgt_done", {31'd0, done}, 32'd0);
         check("badtgt_hold", {31'd0, cpu_hold}, 32'd1);
         return;
      end
      chk = f.target;
      send_byte(f.addr);
      chk ^= f.addr;
      send_byte(f.count);
      chk ^= f.count;
      a = f.addr[ADDR_W-1:0];
      for (int w = 0; w < int'(f.count); w++) begin
         for (int k = 0; k < 4; k++) begin
            b = f.words[w][31-8*k -: 8];
            chk ^= b;
            if (k == 3) begin
               e.dmem = f.target[0];
               e.addr = a;
               e.data = f.words[w];
               exp_q.push_back(e);
               a = a + 1'b1;
            end
            send_byte(b);
         end
      end
      send_byte(f.bad_chk ? f.chk_val : chk);
      check("frame_done", {31'd0, done}, {31'd0, f.exp_done});
      check("frame_err", {31'd0, err}, {31'd0, f.exp_err});
      check("frame_hold", {31'd0, cpu_hold}, {31'd0, ~f.exp_done});
      check("sb_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      //            target addr   count words                      bad  chk    done err
      tbl[0] = '{8'h00, 8'h00, 8'd1, {32'h0, 32'h20080005},         1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{8'h01, 8'h3F, 8'd2, {32'h22222222, 32'h11111111}, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 8'd1, {32'h0, 32'h20080005},         1'b1, 8'h29, 1'b0, 1'b1};
      tbl[3] = '{8'h01, 8'h45, 8'd1, {32'h0, 32'hA5A5A5A5},         1'b0, 8'h00, 1'b1, 1'b0};
      tbl[4] = '{8'h02, 8'h00, 8'd0, {32'h0, 32'h0},                1'b0, 8'h00, 1'b0, 1'b1};
      tbl[5] = '{8'h00, 8'h05, 8'd0, {32'h0, 32'h0},                1'b0, 8'h00, 1'b1, 1'b0};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single-word imem, wrapping dmem, bad checksum, then recovery with 0xA5 data.
      for (int i = 0; i < 4; i++) begin
         send_frame(tbl[i]);
         idle(2);
      end

      // Junk in IDLE, invalid target, then an empty frame.
      send_byte(8'h13);
      send_byte(8'h77);
      send_frame(tbl[4]);
      idle(2);
      send_frame(tbl[5]);
      idle(2);

      // Reset after the second data byte of a word.
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(tbl[0]);
      idle(2);

      // Back-to-back frames with in_valid held high.
      send_frame(tbl[1]);
      send_frame(tbl[3]);
      idle(3);
      check("final_sb_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
